// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the two-port memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick between instruction and data requests
// iReq/dReq: pending requests; lastGrant: owner of the previous grant
// grant: chosen owner (meaningful when any request is high); conflict: both requests high
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic iReq,
  input  logic dReq,
  input  logic lastGrant,
  output logic grant,
  output logic conflict
);
  always_comb begin
    conflict = iReq & dReq;
    grant = conflict ? ~lastGrant : (dReq ? OWN_D : OWN_I);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache/dcache miss traffic onto one shared memory port
// CLK/Reset: system clock, async active-high reset
// iMReq/iMAddr -> iMReady/iMRD: instruction-cache port (read only)
// dMReq/dMAddr/dMWE/dMWD -> dMReady/dMRD: data-cache port
// mReq/mAddr/mWE/mWD <- mReady/mRD: shared memory port, all outputs registered
// ConflictCnt: saturating count of idle cycles with both requests high
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              iMReq,
  input  logic [ADDR_W-1:0] iMAddr,
  output logic              iMReady,
  output logic [DATA_W-1:0] iMRD,
  input  logic              dMReq,
  input  logic [ADDR_W-1:0] dMAddr,
  input  logic              dMWE,
  input  logic [DATA_W-1:0] dMWD,
  output logic              dMReady,
  output logic [DATA_W-1:0] dMRD,
  output logic              mReq,
  output logic [ADDR_W-1:0] mAddr,
  output logic              mWE,
  output logic [DATA_W-1:0] mWD,
  input  logic              mReady,
  input  logic [DATA_W-1:0] mRD,
  output logic [CNT_W-1:0]  ConflictCnt
);
  logic [1:0] state;
  logic owner;
  logic lastGrant;
  logic grant;
  logic conflict;
  logic [DATA_W-1:0] rdata;
  rr_arb2 uArb (
    .iReq(iMReq),
    .dReq(dMReq),
    .lastGrant(lastGrant),
    .grant(grant),
    .conflict(conflict)
  );
  assign iMRD = rdata;
  assign dMRD = rdata;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      owner <= OWN_I;
      lastGrant <= OWN_I;
      mReq <= 1'b0;
      mAddr <= '0;
      mWE <= 1'b0;
      mWD <= '0;
      rdata <= '0;
      iMReady <= 1'b0;
      dMReady <= 1'b0;
      ConflictCnt <= '0;
    end else begin
      iMReady <= 1'b0;
      dMReady <= 1'b0;
      case (state)
        IDLE: begin
          if (iMReq | dMReq) begin
            owner <= grant;
            state <= BUSY;
            mReq <= 1'b1;
            mAddr <= grant ? dMAddr : iMAddr;
            mWE <= grant & dMWE;
            mWD <= grant ? dMWD : '0;
          end
          if (conflict && !(&ConflictCnt)) ConflictCnt <= ConflictCnt + CNT_W'(1);
        end
        BUSY: begin
          if (mReady) begin
            rdata <= mRD;
            lastGrant <= owner;
            mReq <= 1'b0;
            state <= RESP;
            iMReady <= owner == OWN_I;
            dMReady <= owner == OWN_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic iMReq = 1'b0;
  logic [31:0] iMAddr = '0;
  logic dMReq = 1'b0;
  logic [31:0] dMAddr = '0;
  logic dMWE = 1'b0;
  logic [31:0] dMWD = '0;
  logic mReady = 1'b0;
  logic [31:0] mRD = '0;
  logic iMReady, dMReady, mReq, mWE;
  logic [31:0] iMRD, dMRD, mAddr, mWD;
  logic [15:0] ConflictCnt;
  logic iMReady4, dMReady4, mReq4, mWE4;
  logic [31:0] iMRD4, dMRD4, mAddr4, mWD4;
  logic [3:0] ConflictCnt4;
  always #5 CLK = ~CLK;
  mem_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .iMReq(iMReq), .iMAddr(iMAddr), .iMReady(iMReady), .iMRD(iMRD),
    .dMReq(dMReq), .dMAddr(dMAddr), .dMWE(dMWE), .dMWD(dMWD), .dMReady(dMReady), .dMRD(dMRD),
    .mReq(mReq), .mAddr(mAddr), .mWE(mWE), .mWD(mWD), .mReady(mReady), .mRD(mRD),
    .ConflictCnt(ConflictCnt)
  );
  mem_arbiter #(.CNT_W(4)) dut4 (
    .CLK(CLK), .Reset(Reset),
    .iMReq(iMReq), .iMAddr(iMAddr), .iMReady(iMReady4), .iMRD(iMRD4),
    .dMReq(dMReq), .dMAddr(dMAddr), .dMWE(dMWE), .dMWD(dMWD), .dMReady(dMReady4), .dMRD(dMRD4),
    .mReq(mReq4), .mAddr(mAddr4), .mWE(mWE4), .mWD(mWD4), .mReady(mReady), .mRD(mRD),
    .ConflictCnt(ConflictCnt4)
  );
  int memWait = 0;
  int memCnt = 0;
  logic useAddr = 1'b0;
  logic [31:0] memData = '0;
  always @(negedge CLK) begin
    if (Reset || !mReq) begin
      memCnt <= 0;
      mReady <= 1'b0;
    end else if (!mReady) begin
      if (memCnt == memWait) begin
        mReady <= 1'b1;
        mRD <= useAddr ? ~mAddr : memData;
      end else memCnt <= memCnt + 1;
    end
  end
  int nChecks = 0;
  int nPass = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  int iPulses, dPulses, iCycle, dCycle, reqCycle;
  logic opsBad;
  logic [31:0] iData, dData;
  task automatic txn(input int cycles, input logic [31:0] eAddr, input logic eWE, input logic [31:0] eWD);
    iPulses = 0; dPulses = 0; iCycle = -1; dCycle = -1; reqCycle = -1; opsBad = 1'b0;
    iData = '0; dData = '0;
    for (int i = 1; i <= cycles; i++) begin
      tick();
      if (mReq) begin
        if (reqCycle < 0) reqCycle = i;
        if (mAddr !== eAddr || mWE !== eWE || mWD !== eWD) opsBad = 1'b1;
      end
      if (iMReady) begin iPulses++; iCycle = i; iData = iMRD; iMReq = 1'b0; end
      if (dMReady) begin dPulses++; dCycle = i; dData = dMRD; dMReq = 1'b0; end
    end
  endtask
  logic order [3];
  int pCyc [3];
  logic [31:0] pData [3];
  int nPulse;
  logic [15:0] c8;
  logic [3:0] c40, c43;
  int n5, first5, second5;
  logic re5;
  initial begin
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("reset_mReq", mReq, 0);
    check("reset_iMReady", iMReady, 0);
    check("reset_dMReady", dMReady, 0);
    check("reset_cnt", ConflictCnt, 0);
    check("reset_mAddr", mAddr, 0);
    check("reset_mWE", mWE, 0);
    memWait = 2; memData = 32'h2010000A; useAddr = 1'b0;
    iMReq = 1'b1; iMAddr = 32'h40;
    txn(10, 32'h40, 1'b0, 32'h0);
    check("ird_mreq_cycle", reqCycle, 1);
    check("ird_ops_stable", opsBad, 0);
    check("ird_pulses", iPulses, 1);
    check("ird_ready_cycle", iCycle, 4);
    check("ird_data", iData, 32'h2010000A);
    check("ird_d_pulses", dPulses, 0);
    memWait = 1; memData = 32'h12345678;
    dMReq = 1'b1; dMWE = 1'b1; dMAddr = 32'h80; dMWD = 32'hDEADBEEF;
    txn(8, 32'h80, 1'b1, 32'hDEADBEEF);
    dMWE = 1'b0;
    check("dwr_ops_stable", opsBad, 0);
    check("dwr_pulses", dPulses, 1);
    check("dwr_ready_cycle", dCycle, 3);
    check("dwr_data", dData, 32'h12345678);
    check("dwr_i_pulses", iPulses, 0);
    check("dwr_cnt", ConflictCnt, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    memWait = 0; useAddr = 1'b1;
    iMReq = 1'b1; iMAddr = 32'h100;
    dMReq = 1'b1; dMAddr = 32'h200; dMWE = 1'b0;
    nPulse = 0; c8 = '0; c40 = '0; c43 = '0;
    for (int i = 0; i < 3; i++) begin order[i] = 1'bx; pCyc[i] = -1; pData[i] = '0; end
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (iMReady || dMReady) begin
        if (nPulse < 3) begin
          order[nPulse] = dMReady;
          pCyc[nPulse] = i;
          pData[nPulse] = dMReady ? dMRD : iMRD;
        end
        nPulse++;
      end
      if (i == 8) c8 = ConflictCnt;
      if (i == 40) c40 = ConflictCnt4;
      if (i == 43) c43 = ConflictCnt4;
    end
    check("conf_first_owner", order[0], 1);
    check("conf_second_owner", order[1], 0);
    check("conf_third_owner", order[2], 1);
    check("conf_first_cycle", pCyc[0], 2);
    check("conf_second_cycle", pCyc[1], 5);
    check("conf_third_cycle", pCyc[2], 8);
    check("conf_i_data", pData[1], 32'hFFFFFEFF);
    check("conf_cnt_after3", c8, 3);
    check("sat_cnt4_14", c40, 14);
    check("sat_cnt4_15", c43, 15);
    check("sat_cnt4_hold", ConflictCnt4, 15);
    check("sat_cnt16_20", ConflictCnt, 20);
    iMReq = 1'b0; dMReq = 1'b0;
    repeat (4) tick();
    memWait = 5;
    iMReq = 1'b1; iMAddr = 32'h44;
    tick();
    tick();
    check("rst_pre_mReq", mReq, 1);
    #2 Reset = 1'b1;
    #1;
    check("rst_async_mReq", mReq, 0);
    check("rst_async_iMReady", iMReady, 0);
    check("rst_async_dMReady", dMReady, 0);
    check("rst_async_cnt", ConflictCnt, 0);
    check("rst_async_cnt4", ConflictCnt4, 0);
    iMReq = 1'b0;
    Reset = 1'b0;
    tick();
    memWait = 1;
    iMReq = 1'b1; iMAddr = 32'h48;
    txn(8, 32'h48, 1'b0, 32'h0);
    check("rst_after_pulses", iPulses, 1);
    check("rst_after_cycle", iCycle, 3);
    check("rst_after_data", iData, 32'hFFFFFFB7);
    memWait = 0;
    iMReq = 1'b1; iMAddr = 32'h4C;
    n5 = 0; first5 = -1; second5 = -1; re5 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (iMReady) begin
        n5++;
        if (n5 == 1) first5 = i;
        if (n5 == 2) second5 = i;
        iMReq = 1'b0;
      end else if (n5 == 1 && !re5) begin
        iMReq = 1'b1;
        re5 = 1'b1;
      end
    end
    check("b2b_pulses", n5, 2);
    check("b2b_first_cycle", first5, 2);
    check("b2b_gap", second5 - first5, 3);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the instruction cache and data cache miss/refill ports and one shared backing memory.
- Serialises cache-to-memory transactions and returns each result to its requester with a one-cycle ready pulse.
- Sits directly downstream of both caches and upstream of the unified memory, replacing the separate imem/dmem paths.
- Runs on the system clock, not the gated CPU clock, so it keeps working while the core is suspended.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- CNT_W, 16, width of the conflict counter

- CLK  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- iMReq  in  1  instruction-cache request, held until iMReady
- iMAddr  in  ADDR_W  instruction-cache address
- iMReady  out  1  one-cycle completion pulse to instruction cache
- iMRD  out  DATA_W  read data, valid only while iMReady=1
- dMReq  in  1  data-cache request, held until dMReady
- dMAddr  in  ADDR_W  data-cache address
- dMWE  in  1  data-cache write enable
- dMWD  in  DATA_W  data-cache write data
- dMReady  out  1  one-cycle completion pulse to data cache
- dMRD  out  DATA_W  read data, valid only while dMReady=1
- mReq  out  1  memory request, held until mReady sampled high
- mAddr  out  ADDR_W  memory address (registered)
- mWE  out  1  memory write enable (registered)
- mWD  out  DATA_W  memory write data (registered)
- mReady  in  1  memory completion, sampled on the clock edge
- mRD  in  DATA_W  memory read data, valid while mReady=1
- ConflictCnt  out  CNT_W  saturating count of IDLE cycles with both requests high

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY: mReq=1, waiting for mReady.
  - RESP: Ready pulse to the owner.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that did not win the last grant. lastGrant resets to instruction, so the first conflict goes to data. ConflictCnt increments, saturating at all-ones.
  - On grant: latch owner; register mAddr/mWE/mWD from the winner (mWE=0, mWD=0 for instruction); go to BUSY.
- BUSY:
  - mReq=1; mAddr/mWE/mWD held stable.
  - On an edge with mReady=1: capture mRD into rdata, set lastGrant=owner, go to RESP.
- RESP:
  - Owner's Ready=1 for exactly one cycle; the other port's Ready=0.
  - iMRD and dMRD both show rdata.
  - mReq=0; next state IDLE.
- Writes complete with a Ready pulse like reads. rdata holds whatever the memory returned.
- Requester rules:
  - Hold Req and its operands stable from assertion until the edge on which its Ready is sampled high, then deassert at that edge.
  - Req still high in the following IDLE cycle is treated as a new request.
- Protocol violation (Req dropped during BUSY): the transaction still completes and the Ready pulse is still issued.
- Reset, including mid-transaction:
  - State=IDLE, lastGrant=instruction.
  - mReq=0, mWE=0, mAddr=0, mWD=0, both Ready=0, rdata=0, ConflictCnt=0.
  - Any in-flight memory operation is abandoned. The memory shares Reset.

## Timing
- Request high in IDLE at cycle 0 → mReq=1 from cycle 1.
- mReady high in cycle k≥1 → Ready=1 in cycle k+1.
- Minimum round trip: Req at cycle 0, Ready at cycle 2 (zero-wait memory); arbiter back in IDLE at cycle 3.
- The losing port of a conflict waits at least 3 cycles, and is always served next when both ports keep requesting.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package mem_arb_pkg:
  - State encoding (IDLE, BUSY, RESP).
  - Owner encoding (OWN_I=0, OWN_D=1).
  - Default ADDR_W, DATA_W, CNT_W.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from (iMReq, dMReq, lastGrant), producing grant and conflict.
- Top-level mem_arbiter holds the FSM, the operand and rdata registers, and the counter.

## Test plan
- Instruction read:
  - Stimulus: iMReq=1, iMAddr=0x00000040; memory answers after 2 wait cycles with 0x2010000A.
  - Required: mAddr=0x40 and mWE=0 during BUSY; iMReady pulses exactly once with iMRD=0x2010000A; dMReady stays 0.
- Data write:
  - Stimulus: dMReq=1, dMWE=1, dMAddr=0x00000080, dMWD=0xDEADBEEF.
  - Required: mWE=1, mWD=0xDEADBEEF held through BUSY; dMReady pulses once.
- Simultaneous requests from reset, both held high:
  - Required: data served first, instruction second, data third.
  - Required: ConflictCnt increments once per conflict IDLE cycle.
- Counter saturation:
  - Stimulus: CNT_W=4, more than 15 conflict cycles.
  - Required: ConflictCnt stays at 0xF.
- Reset asserted mid-BUSY (asynchronously, between clock edges):
  - Required: mReq, both Ready and ConflictCnt are 0 immediately, without waiting for a clock edge.
  - Required: after release, a new request completes normally.
- Back-to-back instruction requests (Req reasserted in the IDLE cycle after Ready) with zero-wait memory:
  - Required: second iMReady three cycles after the first.
